// File: rtl/divider_rdx.sv
// Iterative radix-2^BITS_PER_CYCLE restoring divider, unsigned or RISC-V signed DIV/REM.
// Optional macro DIV_EARLY_OUT_EN skips the leading zero digits of the dividend magnitude.
module divider_rdx #(
  parameter int SIZE           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            div_enable_i,
  input  logic            signed_i,
  input  logic [SIZE-1:0] dividend_i,
  input  logic [SIZE-1:0] divisor_i,
  output logic            busy_o,
  output logic            division_finished_out,
  output logic            div_by_zero_o,
  output logic [SIZE-1:0] result_div,
  output logic [SIZE-1:0] result_rem
);

  localparam int BPC   = BITS_PER_CYCLE;
  localparam int N     = SIZE / BPC;
  localparam int RADIX = 1 << BPC;
  localparam int WW    = SIZE + BPC;
  localparam int CW    = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t          r_state, w_next;
  logic [CW-1:0]   r_count, w_count_init;
  logic [SIZE-1:0] r_rem, r_quo, r_divisor;
  logic            r_neg_q, r_neg_r, r_dbz;

  logic            w_div_zero;
  logic [SIZE-1:0] w_a_mag, w_b_mag, w_a_load;
  logic [WW-1:0]   w_shifted, w_div_ext, w_mult;
  logic [SIZE-1:0] w_sub, w_rem_next;
  logic [BPC-1:0]  w_digit;

  assign busy_o     = (r_state != IDLE);
  assign w_div_zero = (divisor_i == '0);
  assign w_a_mag    = (signed_i && dividend_i[SIZE-1]) ? -dividend_i : dividend_i;
  assign w_b_mag    = (signed_i && divisor_i[SIZE-1])  ? -divisor_i  : divisor_i;

`ifdef DIV_EARLY_OUT_EN
  localparam int LZW = $clog2(SIZE + 1);
  logic [LZW-1:0] w_lz, w_lz_r;

  always_comb begin
    w_lz = LZW'(SIZE);
    for (int i = 0; i < SIZE; i++) begin
      if (w_a_mag[i]) w_lz = LZW'(SIZE - 1 - i);
    end
  end

  // Round down so the skipped prefix is a whole number of digits.
  assign w_lz_r       = w_lz & ~LZW'(BPC - 1);
  assign w_a_load     = w_a_mag << w_lz_r;
  assign w_count_init = CW'((SIZE - 32'(w_lz_r)) / BPC);
`else
  assign w_a_load     = w_a_mag;
  assign w_count_init = CW'(N);
`endif

  assign w_shifted = {r_rem, r_quo[SIZE-1 -: BPC]};
  assign w_div_ext = {{BPC{1'b0}}, r_divisor};

  // Multiples grow with d, so the last one that fits is the largest digit.
  always_comb begin
    w_digit = '0;
    w_sub   = '0;
    w_mult  = '0;
    for (int d = 1; d < RADIX; d++) begin
      w_mult = w_div_ext * WW'(d);
      if (w_mult <= w_shifted) begin
        w_digit = BPC'(d);
        w_sub   = w_mult[SIZE-1:0];
      end
    end
  end

  assign w_rem_next = w_shifted[SIZE-1:0] - w_sub;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (div_enable_i) begin
          if (w_div_zero || (w_count_init == '0)) w_next = FIX;
          else                                    w_next = CALC;
        end
      end
      CALC:    if (r_count == CW'(1)) w_next = FIX;
      FIX:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count               <= '0;
      r_rem                 <= '0;
      r_quo                 <= '0;
      r_divisor             <= '0;
      r_neg_q               <= 1'b0;
      r_neg_r               <= 1'b0;
      r_dbz                 <= 1'b0;
      result_div            <= '0;
      result_rem            <= '0;
      div_by_zero_o         <= 1'b0;
      division_finished_out <= 1'b0;
    end else begin
      division_finished_out <= 1'b0;
      case (r_state)
        IDLE: begin
          if (div_enable_i) begin
            r_dbz     <= w_div_zero;
            r_divisor <= w_b_mag;
            r_rem     <= '0;
            r_count   <= w_count_init;
            // A zero divisor keeps the raw dividend so it can be returned as the remainder.
            if (w_div_zero) begin
              r_quo   <= dividend_i;
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
            end else begin
              r_quo   <= w_a_load;
              r_neg_q <= signed_i & (dividend_i[SIZE-1] ^ divisor_i[SIZE-1]);
              r_neg_r <= signed_i & dividend_i[SIZE-1];
            end
          end
        end
        CALC: begin
          r_rem   <= w_rem_next;
          r_quo   <= {r_quo[SIZE-BPC-1:0], w_digit};
          r_count <= r_count - CW'(1);
        end
        FIX: begin
          result_div            <= r_dbz ? '1 : (r_neg_q ? -r_quo : r_quo);
          result_rem            <= r_dbz ? r_quo : (r_neg_r ? -r_rem : r_rem);
          div_by_zero_o         <= r_dbz;
          division_finished_out <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_rdx.sv
// Directed bench for divider_rdx: one instance per BITS_PER_CYCLE of 1 and 4 sharing inputs,
// vector table plus hand sequences for hold-enable, back-to-back and mid-operation reset.
module tb_divider_rdx;

  logic        clk = 1'b0;
  logic        reset;
  logic        divEnable;
  logic        signedMode;
  logic [31:0] dividend;
  logic [31:0] divisor;

  logic        b1Busy, b1Fin, b1Dbz;
  logic [31:0] b1Quo, b1Rem;
  logic        b4Busy, b4Fin, b4Dbz;
  logic [31:0] b4Quo, b4Rem;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  divider_rdx #(.SIZE(32), .BITS_PER_CYCLE(1)) dutBpc1 (
    .clk(clk), .reset(reset), .div_enable_i(divEnable), .signed_i(signedMode),
    .dividend_i(dividend), .divisor_i(divisor), .busy_o(b1Busy),
    .division_finished_out(b1Fin), .div_by_zero_o(b1Dbz),
    .result_div(b1Quo), .result_rem(b1Rem)
  );

  divider_rdx #(.SIZE(32), .BITS_PER_CYCLE(4)) dutBpc4 (
    .clk(clk), .reset(reset), .div_enable_i(divEnable), .signed_i(signedMode),
    .dividend_i(dividend), .divisor_i(divisor), .busy_o(b4Busy),
    .division_finished_out(b4Fin), .div_by_zero_o(b4Dbz),
    .result_div(b4Quo), .result_rem(b4Rem)
  );

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
  } vec_t;

  vec_t vecs[16];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, expected);
    end
  endtask

  // Reference latency: accept edge to finished pulse.
  function automatic int expLatency(input logic s, input logic [31:0] a, input logic [31:0] b, input int bpc);
`ifdef DIV_EARLY_OUT_EN
    logic [31:0] m;
    int          lz;
    if (b == 32'd0) return 1;
    m  = (s && a[31]) ? (32'd0 - a) : a;
    lz = 32;
    for (int i = 0; i < 32; i++) if (m[i]) lz = 31 - i;
    lz = (lz / bpc) * bpc;
    return (32 - lz) / bpc + 1;
`else
    if (b == 32'd0) return 1;
    if (s === 1'bx || a === 'x) return -2;
    return 32 / bpc + 1;
`endif
  endfunction

  // Starts one operation on both instances and measures each latency.
  task automatic applyStimulus(input logic s, input logic [31:0] a, input logic [31:0] b,
                               output int lat1, output int lat4, output logic busyOk);
    @(negedge clk);
    divEnable  = 1'b1;
    signedMode = s;
    dividend   = a;
    divisor    = b;
    @(posedge clk);
    #1;
    divEnable = 1'b0;
    lat1   = -1;
    lat4   = -1;
    busyOk = b1Busy;
    for (int k = 1; k <= 200 && (lat1 < 0 || lat4 < 0); k++) begin
      @(posedge clk);
      #1;
      if (lat1 < 0) begin
        if (b1Fin) lat1 = k;
        else if (!b1Busy) busyOk = 1'b0;
      end
      if (lat4 < 0 && b4Fin) lat4 = k;
    end
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while ((b1Busy || b4Busy) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput(name, {30'd0, b4Busy, b1Busy}, 32'd0);
  endtask

  initial begin
    int          lat1, lat4, pulses, seen;
    logic        busyOk;
    vec_t        v;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0};
    vecs[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0};
    vecs[3]  = '{1'b0, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1};
    vecs[4]  = '{1'b1, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1};
    vecs[5]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0};
    vecs[6]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b0};
    vecs[7]  = '{1'b0, 32'hFFFFFFFF,   32'd3,          32'h55555555,   32'd0,          1'b0};
    vecs[8]  = '{1'b0, 32'd5,          32'd1,          32'd5,          32'd0,          1'b0};
    vecs[9]  = '{1'b0, 32'd0,          32'd9,          32'd0,          32'd0,          1'b0};
    vecs[10] = '{1'b1, 32'hFFFFFFF9,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFF9,   1'b1};
    vecs[11] = '{1'b0, 32'd1000,       32'd10,         32'd100,        32'd0,          1'b0};
    vecs[12] = '{1'b1, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0};
    vecs[13] = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0};
    vecs[14] = '{1'b0, 32'hFFFFFFFF,   32'h10,         32'h0FFFFFFF,   32'hF,          1'b0};
    vecs[15] = '{1'b0, 32'd3,          32'd5,          32'd0,          32'd3,          1'b0};

    reset      = 1'b0;
    divEnable  = 1'b0;
    signedMode = 1'b0;
    dividend   = '0;
    divisor    = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset busy",  {31'd0, b1Busy}, 32'd0);
    checkOutput("reset fin",   {31'd0, b1Fin},  32'd0);
    checkOutput("reset dbz",   {31'd0, b1Dbz},  32'd0);
    checkOutput("reset quo",   b1Quo, 32'd0);
    checkOutput("reset rem",   b1Rem, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 16; i++) begin
      v = vecs[i];
      applyStimulus(v.s, v.a, v.b, lat1, lat4, busyOk);
      checkOutput($sformatf("v%0d bpc1 quo", i), b1Quo, v.q);
      checkOutput($sformatf("v%0d bpc1 rem", i), b1Rem, v.r);
      checkOutput($sformatf("v%0d bpc1 dbz", i), {31'd0, b1Dbz}, {31'd0, v.z});
      checkOutput($sformatf("v%0d bpc1 latency", i), 32'(lat1), 32'(expLatency(v.s, v.a, v.b, 1)));
      checkOutput($sformatf("v%0d bpc1 busy", i), {31'd0, busyOk}, 32'd1);
      checkOutput($sformatf("v%0d bpc4 quo", i), b4Quo, v.q);
      checkOutput($sformatf("v%0d bpc4 rem", i), b4Rem, v.r);
      checkOutput($sformatf("v%0d bpc4 dbz", i), {31'd0, b4Dbz}, {31'd0, v.z});
      checkOutput($sformatf("v%0d bpc4 latency", i), 32'(lat4), 32'(expLatency(v.s, v.a, v.b, 4)));
    end

    // Enable held high while busy, operands changed mid-flight.
    @(negedge clk);
    divEnable  = 1'b1;
    signedMode = 1'b0;
    dividend   = 32'd100;
    divisor    = 32'd7;
    @(posedge clk);
    #1;
    dividend = 32'd999;
    divisor  = 32'd3;
    pulses = 0;
    seen   = 0;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk);
      #1;
      if (b1Fin) begin
        pulses++;
        if (seen == 0) begin
          divEnable = 1'b0;
          seen = 1;
          checkOutput("hold quo", b1Quo, 32'd14);
          checkOutput("hold rem", b1Rem, 32'd2);
        end
      end
    end
    checkOutput("hold pulses", 32'(pulses), 32'd1);
    divEnable = 1'b0;
    waitIdle("hold idle");

    // Back-to-back: enable asserted in the finished cycle.
    @(negedge clk);
    divEnable  = 1'b1;
    dividend   = 32'd100;
    divisor    = 32'd7;
    @(posedge clk);
    #1;
    divEnable = 1'b0;
    seen = 0;
    for (int k = 0; k < 200 && seen == 0; k++) begin
      @(posedge clk);
      #1;
      if (b1Fin) seen = 1;
    end
    checkOutput("b2b first fin", 32'(seen), 32'd1);
    checkOutput("b2b first quo", b1Quo, 32'd14);
    divEnable = 1'b1;
    dividend  = 32'd1000;
    divisor   = 32'd10;
    @(posedge clk);
    #1;
    divEnable = 1'b0;
    checkOutput("b2b accept busy", {31'd0, b1Busy}, 32'd1);
    checkOutput("b2b held quo", b1Quo, 32'd14);
    lat1 = -1;
    for (int k = 1; k <= 200 && lat1 < 0; k++) begin
      @(posedge clk);
      #1;
      if (b1Fin) lat1 = k;
    end
    checkOutput("b2b second latency", 32'(lat1), 32'(expLatency(1'b0, 32'd1000, 32'd10, 1)));
    checkOutput("b2b second quo", b1Quo, 32'd100);
    checkOutput("b2b second rem", b1Rem, 32'd0);
    waitIdle("b2b idle");

    // Reset in the middle of a calculation.
    @(negedge clk);
    divEnable = 1'b1;
    dividend  = 32'hFFFFFFFF;
    divisor   = 32'd3;
    @(posedge clk);
    #1;
    divEnable = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("midreset busy", {31'd0, b1Busy}, 32'd0);
    checkOutput("midreset fin",  {31'd0, b1Fin},  32'd0);
    checkOutput("midreset dbz",  {31'd0, b1Dbz},  32'd0);
    checkOutput("midreset quo",  b1Quo, 32'd0);
    checkOutput("midreset rem",  b1Rem, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      #1;
      if (b1Fin || b4Fin) pulses++;
    end
    checkOutput("midreset pulses", 32'(pulses), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/divider_rdx.md
Name: divider_rdx

Overview:
- Parametrised successor to the single-mode iterative divider used by the core's DIV/REM path.
- Performs unsigned or signed (RISC-V semantics) integer division of SIZE-bit operands.
- Retires BITS_PER_CYCLE quotient bits per clock using a radix-2^BITS_PER_CYCLE restoring datapath.
- Sits in the execute stage beside the multiplier; exposes a start/finished handshake plus a busy flag.

Parameters:
- SIZE, 32, operand and result width in bits; even, 8..64.
- BITS_PER_CYCLE, 1, quotient bits resolved per iteration; one of 1, 2, 4; must divide SIZE.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- div_enable_i  in  1  start request; sampled only when idle.
- signed_i  in  1  1 = signed division/remainder, 0 = unsigned.
- dividend_i  in  SIZE  dividend; sampled on the accepting edge only.
- divisor_i  in  SIZE  divisor; sampled on the accepting edge only.
- busy_o  out  1  high while an operation is in flight.
- division_finished_out  out  1  one-cycle pulse when results are valid.
- div_by_zero_o  out  1  registered flag for the last result; high if divisor was 0.
- result_div  out  SIZE  quotient, held until the next accepted start.
- result_rem  out  SIZE  remainder, held until the next accepted start.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs, the iteration counter and internal registers clear to 0.
  - An operation in flight is abandoned and no finished pulse is generated for it.
- States: IDLE, CALC, FIX.
- IDLE:
  - On an edge with div_enable_i=1, capture operands and signed_i and assert busy_o.
  - If signed_i=1, take operand magnitudes and record the quotient sign (sign_a XOR sign_b) and the remainder sign (sign_a).
  - If divisor_i==0, go to FIX directly; otherwise go to CALC with counter = SIZE/BITS_PER_CYCLE.
- CALC, each edge:
  - Shift the partial remainder left by BITS_PER_CYCLE.
  - Select the largest digit d in 0..2^BITS_PER_CYCLE-1 with d*divisor <= partial remainder, subtract, and shift d into the quotient.
  - Decrement the counter; when it reaches 0, go to FIX.
  - Intermediate width is SIZE+BITS_PER_CYCLE bits; no truncation is permitted.
- FIX, one edge:
  - Apply signs (two's-complement negate where required) and register result_div, result_rem and div_by_zero_o.
  - Pulse division_finished_out=1 for exactly one cycle, drop busy_o and return to IDLE.
- Latency: division_finished_out rises N+1 edges after the accepting edge, where N = SIZE/BITS_PER_CYCLE.
  - Divide-by-zero latency is 1 edge.
- Divide by zero: result_div = all ones, result_rem = dividend (unmodified), div_by_zero_o = 1. This applies in both modes.
- Signed overflow (dividend = -2^(SIZE-1), divisor = -1): result_div = dividend, result_rem = 0, through the normal datapath with no special stall.
- div_enable_i while busy_o=1 is ignored; operand changes while busy have no effect.
- Back-to-back operation: div_enable_i high in the finished-pulse cycle is accepted on the next edge, so there are no dead cycles.
- Results and div_by_zero_o stay stable from the finished pulse until the next accepting edge.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined:
  - On the accepting edge, compute lz = leading-zero count of the dividend magnitude, rounded down to a multiple of BITS_PER_CYCLE.
  - Pre-shift the dividend by lz and load counter = (SIZE-lz)/BITS_PER_CYCLE.
  - If that count is 0 (dividend 0), go straight to FIX.
  - Latency becomes counter+1 edges (minimum 1).
  - Results are identical to the undefined case.
- Undefined: fixed latency N+1 for every nonzero divisor; the leading-zero logic is absent.

Test Plan:
- SIZE=32, BPC=1, unsigned 100/7 -> result_div=14, result_rem=2, finished exactly 33 edges after accept, busy_o high throughout.
- Signed -7/2 (0xFFFFFFF9/0x2) -> result_div=0xFFFFFFFD, result_rem=0xFFFFFFFF. Signed 7/-2 -> 0xFFFFFFFD, 1.
- Divide by zero 5/0, both modes -> result_div=0xFFFFFFFF, result_rem=5, div_by_zero_o=1, finished 1 edge after accept.
- Signed 0x80000000/0xFFFFFFFF -> result_div=0x80000000, result_rem=0. Unsigned same operands -> 0, 0x80000000.
- BPC=4: 0xFFFFFFFF/3 -> 0x55555555, rem 0, latency 9.
- Control corner cases:
  - Enable held high during busy -> single result only.
  - Enable in the finished cycle -> next operation accepted immediately.
  - reset low mid-CALC -> all outputs 0 and no finished pulse.
- DIV_EARLY_OUT_EN, BPC=1: 5/1 -> result_div=5, rem 0, latency 4.
- DIV_EARLY_OUT_EN, BPC=1: 0/9 -> result_div=0, rem 0, latency 1.
